ysyx_25040109_key_search: RTL and testbench

Sequential reverse-lookup table: the inverse of the key→data mux. It holds a small writable table of (key, data) pairs and, given a data value, returns the key and index of the lowest-numbered valid entry holding that data, or a miss. It sits beside the decode/CSR logic in the NPC, where a stored value must be mapped back to its code. One entry is examined per cycle under a valid/ready request and response handshake.

---
 rtl/ysyx_25040109_key_search.sv | 101 ++++++++++
 tb/tb_ysyx_25040109_key_search.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040109_key_search.sv
// Reverse-lookup table: given a data value, find the lowest-indexed valid
// entry holding it and return that entry's key and index (or a miss).
// One entry is compared per cycle; the result is held until consumed.
module ysyx_25040109_key_search #(
  parameter int NR_ENTRY = 4,
  parameter int KEY_LEN  = 7,
  parameter int DATA_LEN = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NR_ENTRY)-1:0] wr_idx,
  input  logic [KEY_LEN-1:0]          wr_key,
  input  logic [DATA_LEN-1:0]         wr_data,
  input  logic                        clr,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [DATA_LEN-1:0]         req_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_hit,
  output logic [KEY_LEN-1:0]          resp_key,
  output logic [$clog2(NR_ENTRY)-1:0] resp_idx,
  output logic                        busy
);
  localparam int IDX_W = $clog2(NR_ENTRY);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                             state;
  logic [NR_ENTRY-1:0]                ent_vld;
  logic [NR_ENTRY-1:0][KEY_LEN-1:0]   ent_key;
  logic [NR_ENTRY-1:0][DATA_LEN-1:0]  ent_data;
  logic [DATA_LEN-1:0]                search_q;
  logic [IDX_W-1:0]                   scan_idx;
  logic                               ent_match;
  logic                               scan_last;

  // Compare always reads the registered table, so a write lands one cycle later.
  assign ent_match = ent_vld[scan_idx] && (ent_data[scan_idx] == search_q);
  assign scan_last = (scan_idx == IDX_W'(NR_ENTRY - 1));

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // Table update: clr drops all valid bits, then a same-edge write re-validates its entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld <= '0;
    end else begin
      if (clr) ent_vld <= '0;
      if (wr_en) begin
        ent_vld[wr_idx]  <= 1'b1;
        ent_key[wr_idx]  <= wr_key;
        ent_data[wr_idx] <= wr_data;
      end
    end
  end

  // Search FSM: latch the query, walk entries upward, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      search_q <= '0;
      scan_idx <= '0;
      resp_hit <= 1'b0;
      resp_key <= '0;
      resp_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            search_q <= req_data;
            scan_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (ent_match) begin
            resp_hit <= 1'b1;
            resp_key <= ent_key[scan_idx];
            resp_idx <= scan_idx;
            state    <= DONE;
          end else if (scan_last) begin
            resp_hit <= 1'b0;
            resp_key <= '0;
            resp_idx <= '0;
            state    <= DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040109_key_search.sv
// Randomized + directed bench for the reverse-lookup table, checked through
// a scoreboard fed by a cycle-level reference model of the lookup rules.
module tb_ysyx_25040109_key_search;
  localparam int N  = 4;
  localparam int KL = 7;
  localparam int DL = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst, wr_en, clr, req_valid, resp_ready;
  logic [IW-1:0] wr_idx;
  logic [KL-1:0] wr_key;
  logic [DL-1:0] wr_data, req_data;
  logic          req_ready, resp_valid, resp_hit, busy;
  logic [KL-1:0] resp_key;
  logic [IW-1:0] resp_idx;

  ysyx_25040109_key_search #(.NR_ENTRY(N), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hit(resp_hit), .resp_key(resp_key), .resp_idx(resp_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hit;
    logic [KL-1:0] key;
    logic [IW-1:0] idx;
    int            cyc;   // cycle in which resp_valid must first be seen
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  bit   started = 0;

  // Reference table and request bookkeeping
  bit            m_v[N];
  logic [KL-1:0] m_k[N];
  logic [DL-1:0] m_d[N];
  bit            m_scan = 0, m_done = 0;
  logic [DL-1:0] m_search;
  int            c0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(string nm);
    n_chk++; n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endfunction

  // Reference: cycle k after acceptance judges entry k against the table as
  // it stood in that cycle; the first valid match ends the search, and
  // running past the last entry is a miss. Table edits apply at the edge.
  always @(posedge clk) begin
    int   k;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_scan = 0; m_done = 0;
      sb.delete();
    end else begin
      if (m_scan) begin
        k = cyc - c0;
        if (m_v[k] && m_d[k] == m_search) begin
          e.hit = 1'b1; e.key = m_k[k]; e.idx = k[IW-1:0]; e.cyc = cyc + 1;
          sb.push_back(e); m_scan = 0; m_done = 1;
        end else if (k == N - 1) begin
          e.hit = 1'b0; e.key = '0; e.idx = '0; e.cyc = cyc + 1;
          sb.push_back(e); m_scan = 0; m_done = 1;
        end
      end else if (m_done) begin
        if (resp_ready) m_done = 0;
      end else if (req_valid) begin
        m_search = req_data; c0 = cyc + 1; m_scan = 1;
      end
      if (clr) for (int i = 0; i < N; i++) m_v[i] = 0;
      if (wr_en) begin
        m_v[wr_idx] = 1; m_k[wr_idx] = wr_key; m_d[wr_idx] = wr_data;
      end
    end
    cyc++;
    started = 1;
  end

  // Monitor: handshake state every cycle, response fields against the scoreboard
  exp_t cur;
  bit   have_cur = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", req_ready, !(m_scan || m_done));
      chk("busy", busy, m_scan || m_done);
      chk("resp_valid", resp_valid, m_done);
      if (resp_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            timeout("unexpected_resp");
          end else begin
            cur = sb.pop_front();
            have_cur = 1;
            chk("resp_latency", cyc, cur.cyc);
          end
        end
        if (have_cur) begin
          chk("resp_hit", resp_hit, cur.hit);
          chk("resp_key", resp_key, cur.key);
          chk("resp_idx", resp_idx, cur.idx);
          if (resp_ready) have_cur = 0;
        end
      end
      if (!m_done && !resp_valid) have_cur = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int idx, input logic [KL-1:0] k, input logic [DL-1:0] d);
    wr_en = 1; wr_idx = idx[IW-1:0]; wr_key = k; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  // Present a request and return just after the edge that accepts it
  task automatic search(input logic [DL-1:0] d);
    bit ok = 0;
    bit idle;
    req_valid = 1; req_data = d;
    for (int n = 0; n < 64 && !ok; n++) begin
      idle = !m_scan && !m_done;
      tick();
      if (idle) ok = 1;
    end
    req_valid = 0; req_data = $urandom;
    if (!ok) timeout("req_accept");
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 64 && !ok; n++) begin
      if (!m_scan && !m_done) ok = 1;
      else tick();
    end
    if (!ok) timeout("wait_idle");
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_idx = 0; wr_key = 0; wr_data = 0; clr = 0;
    req_valid = 0; req_data = 0; resp_ready = 1;

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_key", resp_key, 0);
    chk("rst_resp_idx", resp_idx, 0);
    chk("rst_busy", busy, 0);
    tick(); rst = 0;

    // Empty table search: miss after N compares
    search(32'h0); wait_idle();

    // Basic hit
    wr(0, 7'h11, 32'hA0); wr(1, 7'h22, 32'hB0);
    wr(2, 7'h33, 32'hC0); wr(3, 7'h44, 32'hD0);
    search(32'hC0); wait_idle();

    // Priority: lowest matching index wins
    wr(1, 7'h05, 32'h55); wr(3, 7'h07, 32'h55);
    search(32'h55); wait_idle();

    // Backpressure: result held 5 cycles while a second request waits
    resp_ready = 0;
    search(32'hA0);
    req_valid = 1; req_data = 32'h55;
    for (int n = 0; n < 64 && !m_done; n++) tick();
    if (!m_done) timeout("bp_done");
    repeat (5) tick();
    resp_ready = 1;
    for (int n = 0; n < 64 && !m_scan; n++) tick();
    if (!m_scan) timeout("bp_second_accept");
    req_valid = 0;
    wait_idle();

    // Write lands ahead of the scan pointer -> hit at entry 3
    clr = 1; tick(); clr = 0;
    wr(0, 7'h01, 32'h10); wr(1, 7'h02, 32'h20); wr(2, 7'h03, 32'h30);
    search(32'hEE);
    tick();
    wr(3, 7'h7F, 32'hEE);
    wait_idle();

    // clr during cycle 0 removes the entry-2 match -> miss
    wr(2, 7'h2A, 32'h9C);
    search(32'h9C);
    clr = 1; tick(); clr = 0;
    wait_idle();

    // Reset mid-scan: no response, table emptied
    wr(3, 7'h31, 32'h3C);
    search(32'h3C);
    tick();
    rst = 1; tick(); rst = 0;
    tick();
    search(32'h3C); wait_idle();

    // Randomized traffic over a small data alphabet so hits are common
    for (int n = 0; n < 600; n++) begin
      wr_en      = ($urandom_range(0, 99) < 30);
      wr_idx     = IW'($urandom_range(0, N - 1));
      wr_key     = KL'($urandom);
      wr_data    = 32'h10 + $urandom_range(0, 3);
      clr        = ($urandom_range(0, 99) < 3);
      req_valid  = ($urandom_range(0, 99) < 50);
      req_data   = 32'h10 + $urandom_range(0, 4);
      resp_ready = ($urandom_range(0, 99) < 70);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    wr_en = 0; clr = 0; req_valid = 0; resp_ready = 1; rst = 0;
    tick();
    wait_idle();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
